// File: rtl/controle_buffer.sv
// controle_buffer: framebuffer write controller.
// Two draw requesters share one framebuffer write port through a round-robin
// arbiter. A clear request sweeps the whole frame in raster order, writing
// CLEAR_COLOR to every pixel, while the requesters are held off.
module controle_buffer #(
  parameter int                H_PIXELS    = 240,
  parameter int                V_LINES     = 525,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_start,
  input  logic              req0,
  input  logic [10:0]       x0,
  input  logic [10:0]       y0,
  input  logic [DATA_W-1:0] d0,
  input  logic              req1,
  input  logic [10:0]       x1,
  input  logic [10:0]       y1,
  input  logic [DATA_W-1:0] d1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              wr_en,
  output logic [10:0]       wr_x,
  output logic [10:0]       wr_y,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              clear_done
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  localparam logic [10:0] X_LAST = 11'(H_PIXELS - 1);
  localparam logic [10:0] Y_LAST = 11'(V_LINES - 1);

  state_t      state;
  logic [10:0] cnt_x;
  logic [10:0] cnt_y;
  // last_gnt = 1 means port 1 was granted most recently, so port 0 wins a tie
  logic        last_gnt;

  // Grants are only given in IDLE when no clear is being requested and the
  // block is not in reset; a tie goes to the port not granted most recently.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && state == IDLE && !clear_start) begin
      if (req0 && req1) begin
        if (last_gnt) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Controller FSM: registers granted writes, runs the raster clear sweep and
  // produces the busy / clear_done status.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt_x      <= '0;
      cnt_y      <= '0;
      last_gnt   <= 1'b1;
      wr_en      <= 1'b0;
      wr_x       <= '0;
      wr_y       <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clear_done <= 1'b0;
          busy       <= 1'b0;
          if (clear_start) begin
            state <= CLEAR;
            cnt_x <= '0;
            cnt_y <= '0;
            busy  <= 1'b1;
            wr_en <= 1'b0;
          end else if (gnt0) begin
            wr_en    <= 1'b1;
            wr_x     <= x0;
            wr_y     <= y0;
            wr_data  <= d0;
            last_gnt <= 1'b0;
          end else if (gnt1) begin
            wr_en    <= 1'b1;
            wr_x     <= x1;
            wr_y     <= y1;
            wr_data  <= d1;
            last_gnt <= 1'b1;
          end else begin
            wr_en <= 1'b0;
          end
        end
        CLEAR: begin
          wr_en   <= 1'b1;
          wr_x    <= cnt_x;
          wr_y    <= cnt_y;
          wr_data <= CLEAR_COLOR;
          busy    <= 1'b1;
          if (cnt_x == X_LAST) begin
            cnt_x <= '0;
            if (cnt_y == Y_LAST) begin
              cnt_y      <= '0;
              state      <= DONE;
              clear_done <= 1'b1;
            end else begin
              cnt_y <= cnt_y + 11'd1;
            end
          end else begin
            cnt_x <= cnt_x + 11'd1;
          end
        end
        DONE: begin
          state      <= IDLE;
          clear_done <= 1'b0;
          busy       <= 1'b0;
          wr_en      <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
